// File: rtl/byte_unpacker.sv
// byte_unpacker: serialises captured 64-bit words onto an arbitrated 8-bit shared bus
//   clkD        - clock, all state updates on the rising edge
//   rst         - asynchronous active-low reset
//   sharedBus64 - 64-bit word from the upstream producer, valid while readyC is high
//   readyC      - upstream word valid
//   acceptedD   - one-cycle pulse when a word is captured
//   reqD        - bus ownership request, held from capture until the eighth byte is accepted
//   gntD        - bus grant from the arbiter, may drop at any cycle
//   sharedBus   - byte being sent, 8'h00 whenever readyD is low
//   readyD      - sharedBus carries a valid byte
//   acceptedA   - downstream byte acknowledge, only meaningful while readyD is high
module byte_unpacker #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clkD,
    input  logic        rst,
    input  logic [63:0] sharedBus64,
    input  logic        readyC,
    output logic        acceptedD,
    output logic        reqD,
    input  logic        gntD,
    output logic [7:0]  sharedBus,
    output logic        readyD,
    input  logic        acceptedA
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;
    logic [1:0]  state;
    logic [2:0]  byteIdx;
    logic [63:0] wordReg;
    logic [2:0]  lane;
    logic [7:0]  curByte;
    // Byte 0 sits at the bottom of the word in LSB-first mode, at the top otherwise.
    always_comb begin
        lane    = LSB_FIRST ? byteIdx : 3'd7 - byteIdx;
        curByte = wordReg[{lane, 3'b000} +: 8];
    end
    always_ff @(posedge clkD or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            byteIdx   <= 3'd0;
            wordReg   <= 64'd0;
            acceptedD <= 1'b0;
            reqD      <= 1'b0;
            readyD    <= 1'b0;
            sharedBus <= 8'h00;
        end else begin
            acceptedD <= 1'b0;
            case (state)
                IDLE: if (readyC) begin
                    wordReg   <= sharedBus64;
                    byteIdx   <= 3'd0;
                    acceptedD <= 1'b1;
                    reqD      <= 1'b1;
                    state     <= REQ;
                end
                REQ: if (gntD) begin
                    sharedBus <= curByte;
                    readyD    <= 1'b1;
                    state     <= SEND;
                end
                // An acknowledge wins over a simultaneous grant loss; without one the
                // same index is retried after the next grant.
                SEND: if (acceptedA) begin
                    readyD    <= 1'b0;
                    sharedBus <= 8'h00;
                    byteIdx   <= byteIdx + 3'd1;
                    reqD      <= byteIdx != 3'd7;
                    state     <= byteIdx == 3'd7 ? IDLE : GAP;
                end else if (!gntD) begin
                    readyD    <= 1'b0;
                    sharedBus <= 8'h00;
                    state     <= REQ;
                end
                GAP: begin
                    readyD    <= gntD;
                    sharedBus <= gntD ? curByte : 8'h00;
                    state     <= gntD ? SEND : REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_unpacker.sv
// tb_byte_unpacker: directed scoreboard bench for byte_unpacker in both byte orders
module tb_byte_unpacker;
    logic        clkD = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] sharedBus64 = 64'd0;
    logic        readyC = 1'b0;
    logic        gntD = 1'b0;
    logic        acceptedA = 1'b0;
    logic        acceptedD0, reqD0, readyD0, acceptedD1, reqD1, readyD1;
    logic [7:0]  sharedBus0, sharedBus1;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic        prevRdy0 = 1'b0, prevRdy1 = 1'b0;
    logic [7:0]  prevBus0 = 8'h00, prevBus1 = 8'h00;
    int          nAssert = 0;
    int          nFail = 0;
    int          cyc, pulses;

    always #5 clkD = ~clkD;

    byte_unpacker #(.LSB_FIRST(1'b1)) dutLsb (
        .clkD(clkD), .rst(rst), .sharedBus64(sharedBus64), .readyC(readyC),
        .acceptedD(acceptedD0), .reqD(reqD0), .gntD(gntD), .sharedBus(sharedBus0),
        .readyD(readyD0), .acceptedA(acceptedA)
    );
    byte_unpacker #(.LSB_FIRST(1'b0)) dutMsb (
        .clkD(clkD), .rst(rst), .sharedBus64(sharedBus64), .readyC(readyC),
        .acceptedD(acceptedD1), .reqD(reqD1), .gntD(gntD), .sharedBus(sharedBus1),
        .readyD(readyD1), .acceptedA(acceptedA)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkD);
        #1;
    endtask

    function automatic logic [7:0] byteOf(input logic [63:0] w, input int idx, input bit lsb);
        int lane;
        lane = lsb ? idx : 7 - idx;
        return w[lane*8 +: 8];
    endfunction

    task automatic pushWord(input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            q0.push_back(byteOf(w, i, 1'b1));
            q1.push_back(byteOf(w, i, 1'b0));
        end
    endtask

    task automatic capture(input logic [63:0] w);
        pushWord(w);
        sharedBus64 = w;
        readyC = 1'b1;
        tick();
        chk("accepted_pulse", {acceptedD1, acceptedD0}, 2'b11);
        chk("req_after_capture", {reqD1, reqD0}, 2'b11);
        readyC = 1'b0;
        sharedBus64 = 64'd0;
    endtask

    task automatic waitReady();
        for (int i = 0; i < 20 && !readyD0; i++) tick();
        chk("wait_ready", {readyD1, readyD0}, 2'b11);
    endtask

    task automatic acceptOne();
        waitReady();
        acceptedA = 1'b1;
        tick();
        acceptedA = 1'b0;
        chk("ready_drop_after_ack", {readyD1, readyD0}, 2'b00);
    endtask

    // Scoreboard: every acknowledged byte is popped and compared; idle bus must be zero
    // and a presented byte must stay put until it leaves the bus.
    always @(negedge clkD) begin
        if (readyD0 && prevRdy0) chk("bus0_stable", sharedBus0, prevBus0);
        if (readyD1 && prevRdy1) chk("bus1_stable", sharedBus1, prevBus1);
        if (!readyD0) chk("bus0_idle_zero", sharedBus0, 8'h00);
        if (!readyD1) chk("bus1_idle_zero", sharedBus1, 8'h00);
        if (readyD0 && acceptedA) begin
            chk("q0_has_entry", q0.size() > 0, 1'b1);
            if (q0.size() > 0) chk("bus0_byte", sharedBus0, q0.pop_front());
        end
        if (readyD1 && acceptedA) begin
            chk("q1_has_entry", q1.size() > 0, 1'b1);
            if (q1.size() > 0) chk("bus1_byte", sharedBus1, q1.pop_front());
        end
        prevRdy0 = readyD0;
        prevRdy1 = readyD1;
        prevBus0 = sharedBus0;
        prevBus1 = sharedBus1;
    end

    initial begin
        #2 rst = 1'b0;
        readyC = 1'b1;
        sharedBus64 = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        tick();
        chk("reset_outputs0", {acceptedD0, reqD0, readyD0, sharedBus0}, 11'd0);
        chk("reset_outputs1", {acceptedD1, reqD1, readyD1, sharedBus1}, 11'd0);
        readyC = 1'b0;
        rst = 1'b1;
        tick();
        chk("idle_after_release", {reqD1, reqD0, acceptedD1, acceptedD0}, 4'd0);

        // Full-speed word: grant and acknowledge always high.
        gntD = 1'b1;
        acceptedA = 1'b1;
        capture(64'h0807_0605_0403_0201);
        cyc = 0;
        pulses = 0;
        for (int i = 0; i < 40 && reqD0; i++) begin
            tick();
            cyc++;
            pulses += acceptedD0;
        end
        chk("word_cycles", cyc, 16);
        chk("extra_accepted_pulses", pulses, 0);
        chk("q0_drained_fast", q0.size(), 0);
        chk("q1_drained_fast", q1.size(), 0);
        acceptedA = 1'b0;

        // Grant withheld for five cycles after capture.
        gntD = 1'b0;
        capture(64'h1122_3344_5566_7788);
        for (int i = 0; i < 5; i++) begin
            chk("wait_grant_state", {reqD0, readyD0, reqD1, readyD1}, 4'b1010);
            tick();
        end
        gntD = 1'b1;
        tick();
        chk("first_byte_ready", {readyD1, readyD0}, 2'b11);
        chk("first_byte_lsb", sharedBus0, 8'h88);
        chk("first_byte_msb", sharedBus1, 8'h11);
        for (int i = 0; i < 8; i++) acceptOne();
        chk("req_drop_late_grant", {reqD1, reqD0}, 2'b00);

        // Grant lost on byte 3 without acknowledge: byte 3 is retried.
        capture(64'hF0E1_D2C3_B4A5_9687);
        for (int i = 0; i < 3; i++) acceptOne();
        waitReady();
        chk("byte3_lsb", sharedBus0, 8'hB4);
        chk("byte3_msb", sharedBus1, 8'hC3);
        gntD = 1'b0;
        tick();
        chk("grant_lost_ready", {readyD1, readyD0}, 2'b00);
        chk("grant_lost_req", {reqD1, reqD0}, 2'b11);
        tick();
        chk("grant_lost_hold", {readyD1, readyD0}, 2'b00);
        gntD = 1'b1;
        waitReady();
        chk("byte3_retry_lsb", sharedBus0, 8'hB4);
        chk("byte3_retry_msb", sharedBus1, 8'hC3);
        for (int i = 0; i < 5; i++) acceptOne();
        chk("q0_drained_retry", q0.size(), 0);
        chk("req_drop_retry", {reqD1, reqD0}, 2'b00);

        // Acknowledge and grant loss on the same edge for byte 5: the byte counts.
        capture(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 5; i++) acceptOne();
        waitReady();
        acceptedA = 1'b1;
        gntD = 1'b0;
        tick();
        acceptedA = 1'b0;
        chk("ack_wins_ready", {readyD1, readyD0}, 2'b00);
        tick();
        chk("ack_wins_req_wait", {readyD1, readyD0, reqD1, reqD0}, 4'b0011);
        gntD = 1'b1;
        tick();
        chk("byte6_lsb", sharedBus0, 8'h23);
        chk("byte6_msb", sharedBus1, 8'hCD);
        for (int i = 0; i < 2; i++) acceptOne();
        chk("q1_drained_ack_wins", q1.size(), 0);

        // Reset mid-word discards the remainder.
        capture(64'h5A5B_5C5D_5E5F_6061);
        for (int i = 0; i < 4; i++) acceptOne();
        waitReady();
        #2 rst = 1'b0;
        #1;
        chk("async_reset0", {acceptedD0, reqD0, readyD0, sharedBus0}, 11'd0);
        chk("async_reset1", {acceptedD1, reqD1, readyD1, sharedBus1}, 11'd0);
        q0.delete();
        q1.delete();
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_after_mid_reset", {reqD1, reqD0, readyD1, readyD0}, 4'd0);
        capture({8{8'hAA}});
        for (int i = 0; i < 8; i++) acceptOne();
        chk("q0_drained_after_reset", q0.size(), 0);
        chk("q1_drained_after_reset", q1.size(), 0);
        chk("req_drop_after_reset", {reqD1, reqD0}, 2'b00);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
